// File: rtl/vga_patgen.sv
// Multi-mode test-pattern source for the pixel-clock domain: colour bars, crosshatch,
// grey ramp, checkerboard, solid fill and moving bar, with an optional white border.
module vga_patgen #(
  parameter int BPC       = 8,
  parameter int HW        = 12,
  parameter int VW        = 12,
  parameter int GRID_LOG2 = 5,
  parameter int CHK_LOG2  = 4,
  parameter int MOV_STEP  = 4,
  parameter int MOV_WIDTH = 16,
  localparam int BPP      = 3 * BPC
) (
  input  logic           i_pixclk,
  input  logic           i_reset_n,
  input  logic [HW-1:0]  i_width,
  input  logic [VW-1:0]  i_height,
  input  logic [2:0]     i_mode,
  input  logic [BPP-1:0] i_color,
  input  logic           i_border,
  input  logic           i_rd,
  input  logic           i_newline,
  input  logic           i_newframe,
  output logic [BPP-1:0] o_pixel,
  output logic [2:0]     o_mode
);

  logic [HW-1:0]  hpos;
  logic [VW-1:0]  ypos;
  logic [2:0]     bar;
  logic [HW-1:0]  bar_edge;
  logic [HW-1:0]  mov_pos;
  logic [2:0]     mode_r;
  logic           border_r;
  logic           dline;

  logic [HW-1:0]  step;
  logic [HW:0]    mov_sum;
  logic [HW:0]    mov_end;
  logic [HW:0]    hpos_inc;
  logic           edge_hit;
  logic           on_border;
  logic [BPP-1:0] pattern;

  assign step     = i_width >> 3;
  assign mov_sum  = {1'b0, mov_pos} + (HW+1)'(MOV_STEP);
  assign mov_end  = {1'b0, mov_pos} + (HW+1)'(MOV_WIDTH);
  // Extra bit keeps a zero bar_edge (width < 8) from ever matching on hpos wrap.
  assign hpos_inc = {1'b0, hpos} + (HW+1)'(1);
  assign edge_hit = (hpos_inc == {1'b0, bar_edge});

  assign on_border = border_r && ((hpos == '0) || (hpos == i_width - HW'(1)) ||
                                  (ypos == '0) || (ypos == i_height - VW'(1)));

  always_comb begin
    pattern = '0;
    case (mode_r)
      // R = ~bar[1], G = ~bar[2], B = ~bar[0] gives white..black in broadcast order.
      3'd0: pattern = {{BPC{~bar[1]}}, {BPC{~bar[2]}}, {BPC{~bar[0]}}};
      3'd1: if ((hpos[GRID_LOG2-1:0] == '0) || (ypos[GRID_LOG2-1:0] == '0)) pattern = '1;
      3'd2: pattern = {3{hpos[BPC-1:0]}};
      3'd3: if (hpos[CHK_LOG2] ^ ypos[CHK_LOG2]) pattern = '1;
      3'd4: pattern = i_color;
      3'd5: if (({1'b0, hpos} >= {1'b0, mov_pos}) && ({1'b0, hpos} < mov_end)) pattern = '1;
      default: pattern = '0;
    endcase
    if (on_border) pattern = '1;
  end

  always_ff @(posedge i_pixclk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      hpos     <= '0;
      ypos     <= '0;
      bar      <= '0;
      bar_edge <= '0;
      mov_pos  <= '0;
      mode_r   <= '0;
      border_r <= 1'b0;
      dline    <= 1'b0;
      o_pixel  <= '0;
    end else if (i_newframe) begin
      hpos     <= '0;
      ypos     <= '0;
      bar      <= '0;
      bar_edge <= step;
      dline    <= 1'b0;
      mode_r   <= i_mode;
      border_r <= i_border;
      mov_pos  <= (mov_sum >= {1'b0, i_width}) ? '0 : mov_sum[HW-1:0];
    end else if (i_newline) begin
      hpos     <= '0;
      bar      <= '0;
      bar_edge <= step;
      dline    <= 1'b0;
      if (dline) ypos <= ypos + VW'(1);
    end else if (i_rd) begin
      o_pixel <= pattern;
      dline   <= 1'b1;
      hpos    <= hpos_inc[HW-1:0];
      if (edge_hit && (bar != 3'd7)) begin
        bar      <= bar + 3'd1;
        bar_edge <= bar_edge + step;
      end
    end
  end

  assign o_mode = mode_r;

endmodule

// File: doc/vga_patgen.md
Name: vga_patgen

Overview:
- Parametrised, multi-mode successor to the single-pattern colour-bar test source.
- Sits in the pixel-clock domain between the VGA timing generator (i_rd/i_newline/i_newframe) and the video output or framebuffer mux.
- Generates one of six run-time-selectable test patterns with an optional white border.
- Mode and border are latched per frame, so patterns never tear mid-frame.

Parameters:
- BPC, 8, bits per colour component; BPP = 3*BPC, R in MSBs, then G, then B.
- HW, 12, width of the horizontal position/width counters.
- VW, 12, width of the vertical position/height counters.
- GRID_LOG2, 5, crosshatch line spacing is 2^GRID_LOG2 pixels.
- CHK_LOG2, 4, checkerboard square size is 2^CHK_LOG2 pixels.
- MOV_STEP, 4, moving-bar advance in pixels per frame.
- MOV_WIDTH, 16, moving-bar width in pixels.

Ports:
- i_pixclk  in  1  pixel clock.
- i_reset_n  in  1  asynchronous active-low reset.
- i_width  in  HW  active pixels per line.
- i_height  in  VW  active lines per frame.
- i_mode  in  3  requested pattern; sampled only at i_newframe.
- i_color  in  BPP  solid-fill colour for mode 4; used live.
- i_border  in  1  border enable; sampled only at i_newframe.
- i_rd  in  1  consume one pixel.
- i_newline  in  1  start of line.
- i_newframe  in  1  start of frame.
- o_pixel  out  BPP  registered pixel.
- o_mode  out  3  mode currently in effect.

Behaviour:
- Reset (i_reset_n low, async): hpos=0, ypos=0, bar=0, bar_edge=0, mov_pos=0, mode_r=0, border_r=0, dline=0, o_pixel=0, o_mode=0.
- Priority per cycle: i_newframe > i_newline > i_rd. When a higher-priority event is present, i_rd is ignored and o_pixel holds.
- i_newframe:
  - hpos=0, ypos=0, bar=0, bar_edge=i_width>>3, dline=0.
  - mode_r<=i_mode, border_r<=i_border.
  - mov_pos<=mov_pos+MOV_STEP, or 0 if that sum >= i_width. Compare at HW+1 bits, no overflow.
- i_newline:
  - hpos=0, bar=0, bar_edge=i_width>>3, dline=0.
  - ypos+=1 only if dline=1, i.e. at least one i_rd since the last newline/newframe. Back-to-back newlines without reads do not advance ypos.
- i_rd (no higher-priority event):
  - o_pixel<=pattern(hpos,ypos); dline=1; hpos+=1.
  - If hpos+1==bar_edge and bar<7: bar+=1, bar_edge+=i_width>>3.
  - Latency is exactly 1 cycle: the pixel for column k appears on o_pixel the cycle after the (k+1)th i_rd of the line. o_pixel holds between reads.
- Pattern is combinational from hpos, ypos, bar, mode_r, mov_pos. W = all-ones; K = zero; component ones/zeros = {BPC{1}}/{BPC{0}}.
  - Mode 0, colour bars by bar index 0..7: white, yellow, cyan, green, magenta, red, blue, black.
  - Mode 1, crosshatch: W if hpos[GRID_LOG2-1:0]==0 or ypos[GRID_LOG2-1:0]==0, else K.
  - Mode 2, grey ramp: each component = hpos[BPC-1:0]. Wraps every 2^BPC pixels.
  - Mode 3, checkerboard: W if hpos[CHK_LOG2]^ypos[CHK_LOG2], else K.
  - Mode 4, solid: i_color.
  - Mode 5, moving bar: W if mov_pos <= hpos < mov_pos+MOV_WIDTH (HW+1-bit compare), else K. mov_pos advances every frame regardless of mode.
  - Modes 6, 7: K.
- Border: if border_r and (hpos==0, hpos==i_width-1, ypos==0 or ypos==i_height-1), the pixel is W. Border overrides every mode.
- Boundaries:
  - i_width<8: step=0, bar stays 0, whole line white in mode 0.
  - bar saturates at 7. Extra pixels past 8*(i_width>>3) stay black.
  - hpos/ypos wrap modulo 2^HW / 2^VW if the timing generator over-reads; no other effect.
  - i_mode/i_border changes mid-frame have no effect until the next i_newframe.
  - Reset asserted mid-line forces the outputs to their reset values immediately. The first pixel after reset release uses mode 0, no border.
- o_mode = mode_r.

Test Plan:
- Reset, then newframe with i_mode=0, i_width=64, i_height=4, 64 reads -> o_pixel white for columns 0-7, yellow 8-15, ..., black 56-63; each pixel 1 cycle after its i_rd.
- i_mode=1, GRID_LOG2=5, width 64, lines 0..32 -> line 0 all W; line 1 W only at columns 0 and 32; line 32 all W.
- i_mode=4, i_color=0x123456, i_border=1, width 16, height 3 -> rows 0 and 2 all 0xFFFFFF; row 1 0xFFFFFF at columns 0 and 15, 0x123456 elsewhere.
- Mode 5, width 20, 6 newframes -> mov_pos sequence 4, 8, 12, 16, 0, 4; bar W at columns mov_pos..mov_pos+15 (clipped at line end).
- Change i_mode from 0 to 2 mid-frame -> pattern and o_mode unchanged until the next i_newframe; then column 37 gives 0x252525.
- i_newline and i_rd in the same cycle -> hpos=0, o_pixel held. Three newlines with no reads -> ypos unchanged.
- Async reset pulse mid-line -> o_pixel=0 immediately, without waiting for a clock edge.
